// File: rtl/scoreboard_req_arb.sv
// scoreboard_req_arb
//   Round-robin arbiter sharing one scoreboard request channel among
//   NUM_REQS issue-slice requesters. The winner's payload and index are
//   pushed into a 2-entry elastic buffer. ready_in is derived only from
//   the buffer occupancy, never from ready_out, so no combinational path
//   runs from the scoreboard back to the requesters.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   valid_in   in   [NUM_REQS]        per-requester request valid
//   data_in    in   [NUM_REQS*DATAW]  payloads, requester i at [i*DATAW +: DATAW]
//   ready_in   out  [NUM_REQS]        per-requester accept, one-hot or zero
//   valid_out  out                    head entry valid
//   data_out   out  [DATAW]           head entry payload
//   sel_out    out  [SELW]            head entry requester index
//   ready_out  in                     scoreboard accepts head entry

module scoreboard_req_arb #(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 64,
    parameter int SELW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQS-1:0]       valid_in,
    input  logic [NUM_REQS*DATAW-1:0] data_in,
    output logic [NUM_REQS-1:0]       ready_in,
    output logic                      valid_out,
    output logic [DATAW-1:0]          data_out,
    output logic [SELW-1:0]           sel_out,
    input  logic                      ready_out
);

    logic [SELW-1:0]  rr_ptr;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [DATAW-1:0] data_mem [2];
    logic [SELW-1:0]  sel_mem  [2];

    logic [DATAW-1:0] req_data [NUM_REQS];
    logic             found;
    logic [SELW-1:0]  win;
    logic             not_full;
    logic             push;
    logic             pop;

    for (genvar g = 0; g < NUM_REQS; g++) begin : g_unpack
        assign req_data[g] = data_in[g*DATAW +: DATAW];
    end

    // Scan from rr_ptr upward with wrap; first valid requester wins.
    always_comb begin
        logic [SELW-1:0] idx;
        int              j;
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NUM_REQS) j = j - NUM_REQS;
            idx = SELW'(j);
            if (!found && valid_in[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Gated by reset so ready_in drops the moment reset asserts.
    assign not_full = (count < 2'd2) && !reset;

    always_comb begin
        ready_in = '0;
        if (found && not_full) ready_in[win] = 1'b1;
    end

    assign push      = found && not_full;
    assign valid_out = (count != 2'd0);
    assign pop       = valid_out && ready_out;
    assign data_out  = data_mem[rd_ptr];
    assign sel_out   = sel_mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= '0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            data_mem[0] <= '0;
            data_mem[1] <= '0;
            sel_mem[0]  <= '0;
            sel_mem[1]  <= '0;
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= req_data[win];
                sel_mem[wr_ptr]  <= win;
                wr_ptr           <= ~wr_ptr;
                // Explicit wrap keeps non-power-of-2 NUM_REQS in range.
                if (win == SELW'(NUM_REQS - 1)) rr_ptr <= '0;
                else                            rr_ptr <= win + SELW'(1);
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(ready_in));
    a_count_max: assert property (@(posedge clk) disable iff (reset)
        count <= 2'd2);
    a_out_stable: assert property (@(posedge clk) disable iff (reset)
        (valid_out && !ready_out) |=>
            (valid_out && $stable(data_out) && $stable(sel_out)));

endmodule

// File: tb/tb_scoreboard_req_arb.sv
// tb_scoreboard_req_arb
//   Directed bench for scoreboard_req_arb (NUM_REQS=4, DATAW=64).
//   Requester i always presents payload 0x11*(i+1).

module tb_scoreboard_req_arb;

    localparam int NUM_REQS = 4;
    localparam int DATAW    = 64;
    localparam int SELW     = 2;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQS-1:0]       valid_in;
    logic [NUM_REQS*DATAW-1:0] data_in;
    logic [NUM_REQS-1:0]       ready_in;
    logic                      valid_out;
    logic [DATAW-1:0]          data_out;
    logic [SELW-1:0]           sel_out;
    logic                      ready_out;

    int n_checks = 0;
    int n_fail   = 0;

    scoreboard_req_arb #(.NUM_REQS(NUM_REQS), .DATAW(DATAW)) dut (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .valid_out (valid_out),
        .data_out  (data_out),
        .sel_out   (sel_out),
        .ready_out (ready_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] pay(input int i);
        return 64'h11 * 64'(i + 1);
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        valid_in  = '0;
        ready_out = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) data_in[i*DATAW +: DATAW] = pay(i);

        // Reset state, with requests pending to show ready_in is held low
        tick();
        valid_in = 4'b1111;
        #1;
        check_val("rst_valid_out", valid_out, 0);
        check_val("rst_data_out",  data_out,  0);
        check_val("rst_sel_out",   sel_out,   0);
        check_val("rst_ready_in",  ready_in,  0);
        tick();
        valid_in = '0;
        reset    = 1'b0;
        #1;

        // 1: single requester, first-transaction latency
        valid_in  = 4'b0001;
        ready_out = 1'b1;
        #1;
        check_val("t1_ready_in",   ready_in,  4'b0001);
        check_val("t1_empty",      valid_out, 0);
        tick();
        valid_in = '0;
        #1;
        check_val("t1_valid_out",  valid_out, 1);
        check_val("t1_data_out",   data_out,  pay(0));
        check_val("t1_sel_out",    sel_out,   0);
        tick();
        check_val("t1_drained",    valid_out, 0);

        // 2: all valid, sustained one per cycle in round-robin order
        do_reset();
        valid_in  = 4'b1111;
        ready_out = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check_val($sformatf("t2_grant%0d", k), ready_in, 4'b0001 << (k % 4));
            tick();
            check_val($sformatf("t2_valid%0d", k), valid_out, 1);
            check_val($sformatf("t2_sel%0d", k),   sel_out,   k % 4);
            check_val($sformatf("t2_data%0d", k),  data_out,  pay(k % 4));
        end
        valid_in = '0;
        tick();
        check_val("t2_drained", valid_out, 0);

        // 3: backpressure fills the buffer after exactly two pushes
        valid_in  = 4'b1111;
        ready_out = 1'b0;
        #1;
        check_val("t3_grant0", ready_in, 4'b0001);
        tick();
        check_val("t3_grant1", ready_in, 4'b0010);
        check_val("t3_head0",  sel_out,  0);
        tick();
        check_val("t3_full",   ready_in, 4'b0000);
        tick();
        check_val("t3_full_hold", ready_in, 4'b0000);
        check_val("t3_stable_sel", sel_out, 0);
        check_val("t3_stable_dat", data_out, pay(0));
        ready_out = 1'b1;
        #1;
        check_val("t3_full_rdy_out", ready_in, 4'b0000);
        tick();
        check_val("t3_pop1_sel",  sel_out,  1);
        check_val("t3_pop1_data", data_out, pay(1));
        check_val("t3_next_req2", ready_in, 4'b0100);
        valid_in = '0;
        tick();
        check_val("t3_drained", valid_out, 0);

        // 4: wrap-around from rr_ptr=3
        valid_in = 4'b0100;
        #1;
        check_val("t4_prep_grant", ready_in, 4'b0100);
        tick();
        valid_in = 4'b1001;
        #1;
        check_val("t4_grant3", ready_in, 4'b1000);
        tick();
        check_val("t4_sel3",   sel_out,  3);
        check_val("t4_data3",  data_out, pay(3));
        check_val("t4_grant0", ready_in, 4'b0001);
        tick();
        check_val("t4_sel0",   sel_out,  0);
        valid_in = '0;
        tick();
        check_val("t4_drained", valid_out, 0);

        // 5: simultaneous push and pop at count==1
        valid_in  = 4'b0001;
        ready_out = 1'b0;
        tick();
        check_val("t5_one_sel", sel_out, 0);
        valid_in  = 4'b0100;
        ready_out = 1'b1;
        #1;
        check_val("t5_grant2", ready_in, 4'b0100);
        tick();
        check_val("t5_valid",  valid_out, 1);
        check_val("t5_sel2",   sel_out,   2);
        check_val("t5_data2",  data_out,  pay(2));
        valid_in  = '0;
        ready_out = 1'b0;
        tick();
        check_val("t5_hold_sel", sel_out, 2);
        ready_out = 1'b1;
        tick();
        check_val("t5_count_was_1", valid_out, 0);

        // 6: asynchronous reset with a full buffer
        valid_in  = 4'b1111;
        ready_out = 1'b0;
        tick();
        tick();
        check_val("t6_full_valid", valid_out, 1);
        check_val("t6_full_ready", ready_in,  4'b0000);
        #2;
        reset = 1'b1;
        #1;
        check_val("t6_async_valid", valid_out, 0);
        check_val("t6_async_ready", ready_in,  0);
        check_val("t6_async_sel",   sel_out,   0);
        check_val("t6_async_data",  data_out,  0);
        valid_in = 4'b1010;
        tick();
        reset = 1'b0;
        #1;
        check_val("t6_first_grant", ready_in, 4'b0010);
        tick();
        check_val("t6_sel1",  sel_out,  1);
        check_val("t6_data1", data_out, pay(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
